// File: rtl/fifo_drain_ctrl_pkg.sv
// Shared types and constants for the FIFO-to-memory drain sequencer.
package fifo_drain_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_FINISH
  } state_e;

  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] BE_FULL    = 4'hF;
endpackage

// File: rtl/fifo_drain_ctrl.sv
// Pops words from the receive FIFO over OBI and writes them to consecutive
// memory words, one transaction in flight at a time, with abort and done pulse.
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    CNT_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] FIFO_ADDR  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [CNT_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  remaining_o,
  output logic                  fifo_req_o,
  output logic [ADDR_WIDTH-1:0] fifo_addr_o,
  output logic                  fifo_we_o,
  output logic [3:0]            fifo_be_o,
  input  logic                  fifo_gnt_i,
  input  logic                  fifo_rvalid_i,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i
);

  state_e                r_state, w_state_n;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_n;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_n;
  logic [DATA_WIDTH-1:0] r_data, w_data_n;
  logic                  r_abort, w_abort_n, w_abort;

  always_comb begin
    w_state_n  = r_state;
    w_addr_n   = r_addr;
    w_cnt_n    = r_cnt;
    w_data_n   = r_data;
    // An abort arriving this cycle counts as pending, so it can end the run now.
    w_abort    = r_abort | abort_i;
    w_abort_n  = (r_state != S_IDLE) ? w_abort : 1'b0;
    fifo_req_o = 1'b0;
    mem_req_o  = 1'b0;
    done_o     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_addr_n  = dst_addr_i & ~ADDR_WIDTH'(WORD_BYTES - 1);
          w_cnt_n   = len_i;
          w_state_n = (len_i != '0) ? S_RD_REQ : S_FINISH;
        end
      end
      S_RD_REQ: begin
        fifo_req_o = 1'b1;
        if (fifo_gnt_i)   w_state_n = S_RD_WAIT;
        else if (w_abort) w_state_n = S_FINISH;
      end
      S_RD_WAIT: begin
        if (fifo_rvalid_i) begin
          w_data_n  = fifo_rdata_i;
          w_state_n = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) w_state_n = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        // A popped word is always committed before an abort takes effect.
        if (mem_rvalid_i) begin
          w_addr_n  = r_addr + ADDR_WIDTH'(WORD_BYTES);
          w_cnt_n   = r_cnt - CNT_WIDTH'(1);
          w_state_n = (r_cnt == CNT_WIDTH'(1) || w_abort) ? S_FINISH : S_RD_REQ;
        end
      end
      S_FINISH: begin
        done_o    = 1'b1;
        w_abort_n = 1'b0;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_addr  <= w_addr_n;
      r_cnt   <= w_cnt_n;
      r_data  <= w_data_n;
      r_abort <= w_abort_n;
    end
  end

  assign busy_o      = (r_state != S_IDLE);
  assign remaining_o = r_cnt;
  assign fifo_addr_o = FIFO_ADDR;
  assign fifo_we_o   = 1'b0;
  assign fifo_be_o   = BE_FULL;
  assign mem_addr_o  = r_addr;
  assign mem_we_o    = 1'b1;
  assign mem_be_o    = BE_FULL;
  assign mem_wdata_o = r_data;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Scoreboard bench: randomized FIFO/memory slaves, expected writes queued per start,
// a monitor compares every memory handshake and every done pulse.
module tb_fifo_drain_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0;
  logic [AW-1:0] dst = '0;
  logic [CW-1:0] len = '0;
  logic          busy, done;
  logic [CW-1:0] remaining;
  logic          fifo_req, fifo_we;
  logic [AW-1:0] fifo_addr;
  logic [3:0]    fifo_be;
  logic          fifo_gnt = 1'b0, fifo_rvalid = 1'b0;
  logic [DW-1:0] fifo_rdata = '0;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt = 1'b0, mem_rvalid = 1'b0;

  always #5 clk = ~clk;

  fifo_drain_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .dst_addr_i(dst), .len_i(len), .busy_o(busy), .done_o(done),
    .remaining_o(remaining), .fifo_req_o(fifo_req), .fifo_addr_o(fifo_addr),
    .fifo_we_o(fifo_we), .fifo_be_o(fifo_be), .fifo_gnt_i(fifo_gnt),
    .fifo_rvalid_i(fifo_rvalid), .fifo_rdata_i(fifo_rdata), .mem_req_o(mem_req),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference state: FIFO contents, words in pop order, expected write addresses.
  logic [31:0] fifo_q[$];
  logic [31:0] exp_data[$];
  logic [31:0] exp_addr[$];

  int fifo_pct = 100, mem_pct = 100, max_dly = 0;
  bit mem_block = 1'b0;

  // Slave models: decide grants at negedge, rvalid after a random delay.
  bit          f_pend = 1'b0, m_pend = 1'b0;
  int          f_dly = 0, m_dly = 0;
  logic [31:0] f_data = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      fifo_gnt = 1'b0; fifo_rvalid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      f_pend = 1'b0; m_pend = 1'b0;
    end else begin
      fifo_rvalid = 1'b0;
      if (f_pend) begin
        if (f_dly == 0) begin fifo_rvalid = 1'b1; fifo_rdata = f_data; f_pend = 1'b0; end
        else f_dly--;
      end
      fifo_gnt = 1'b0;
      if (fifo_req && !f_pend && fifo_q.size() > 0 && $urandom_range(99) < fifo_pct) begin
        fifo_gnt = 1'b1; f_pend = 1'b1; f_data = fifo_q.pop_front();
        f_dly = $urandom_range(max_dly);
      end
      mem_rvalid = 1'b0;
      if (m_pend) begin
        if (m_dly == 0) begin mem_rvalid = 1'b1; m_pend = 1'b0; end
        else m_dly--;
      end
      mem_gnt = 1'b0;
      if (mem_req && !m_pend && !mem_block && $urandom_range(99) < mem_pct) begin
        mem_gnt = 1'b1; m_pend = 1'b1; m_dly = $urandom_range(max_dly);
      end
    end
  end

  // Monitor
  int          wr_cnt = 0, done_cnt = 0;
  bit          xfer_open = 0, exp_busy = 0, abort_seen = 0, just_started = 0;
  bit          started_len0 = 0, prev_stall = 0, prev_done = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;
  always begin
    @(negedge clk); #1;
    if (!rst_n) begin
      exp_addr.delete();
      xfer_open = 0; exp_busy = 0; just_started = 0; prev_stall = 0; prev_done = 0;
    end else begin
      chk("busy", busy, exp_busy);
      chk("req_exclusive", fifo_req & mem_req, 0);
      if (just_started) begin
        chk("start_fifo_req", fifo_req, started_len0 ? 0 : 1);
        chk("start_done", done, started_len0);
        just_started = 0;
      end
      if (prev_stall && mem_req) begin
        chk("stall_addr", mem_addr, prev_addr);
        chk("stall_data", mem_wdata, prev_data);
      end
      prev_stall = mem_req && !mem_gnt;
      prev_addr  = mem_addr;
      prev_data  = mem_wdata;
      if (mem_req && mem_gnt) begin
        wr_cnt++;
        chk("write_expected", exp_addr.size() > 0 && exp_data.size() > 0, 1);
        if (exp_addr.size() > 0 && exp_data.size() > 0) begin
          chk("wr_addr", mem_addr, exp_addr.pop_front());
          chk("wr_data", mem_wdata, exp_data.pop_front());
        end
      end
      if (done) begin
        chk("done_single", prev_done, 0);
        chk("done_open", xfer_open, 1);
        chk("done_remaining", remaining, exp_addr.size());
        if (!abort_seen) chk("all_written", exp_addr.size(), 0);
        exp_addr.delete();
        xfer_open = 0; exp_busy = 0; done_cnt++;
      end
      prev_done = done;
      if (abort && busy) abort_seen = 1;
      if (start && !busy) begin
        for (int i = 0; i < int'(len); i++)
          exp_addr.push_back((dst & ~32'h3) + 32'(4 * i));
        xfer_open = 1; exp_busy = 1; abort_seen = 0; just_started = 1;
        started_len0 = (len == 0);
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    exp_data.push_back(w);
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) push_word($urandom);
  endtask

  task automatic go(input logic [31:0] d, input int n);
    @(negedge clk);
    dst = d; len = CW'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int limit, input string nm);
    int c = 0;
    while (done_cnt == d0 && c < limit) begin @(negedge clk); #2; c++; end
    chk({nm, "_done_seen"}, done_cnt != d0, 1);
  endtask

  task automatic wait_writes(input int base, input int n, input string nm);
    int c = 0;
    while (wr_cnt - base < n && c < 500) begin @(negedge clk); #2; c++; end
    chk({nm, "_writes_reached"}, wr_cnt - base, n);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_remaining"}, remaining, 0);
    chk({nm, "_fifo_req"}, fifo_req, 0);
    chk({nm, "_mem_req"}, mem_req, 0);
    chk({nm, "_mem_addr"}, mem_addr, 0);
    chk({nm, "_mem_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, w0;
    repeat (3) @(negedge clk);
    #2;
    chk_reset_vals("reset");
    chk("fifo_we", fifo_we, 0);
    chk("fifo_be", fifo_be, 4'hF);
    chk("fifo_addr", fifo_addr, 0);
    chk("mem_we", mem_we, 1);
    chk("mem_be", mem_be, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic three-word transfer
    push_word(32'hAAAA_0001); push_word(32'hBBBB_0002); push_word(32'hCCCC_0003);
    d0 = done_cnt; w0 = wr_cnt;
    go(32'h1000, 3);
    wait_done(d0, 100, "basic");
    chk("basic_writes", wr_cnt - w0, 3);
    chk("basic_remaining", remaining, 0);

    // Empty FIFO stall
    d0 = done_cnt; w0 = wr_cnt;
    go(32'h2000, 2);
    repeat (20) begin
      @(negedge clk); #2;
      chk("stall_fifo_req", fifo_req, 1);
      chk("stall_no_mem_req", mem_req, 0);
    end
    push_words(2);
    wait_done(d0, 100, "stall");
    chk("stall_writes", wr_cnt - w0, 2);

    // Memory back-pressure
    mem_block = 1'b1;
    push_words(1);
    d0 = done_cnt;
    go(32'h3000, 1);
    begin
      int c = 0;
      while (!mem_req && c < 50) begin @(negedge clk); #2; c++; end
    end
    repeat (5) begin
      @(negedge clk); #2;
      chk("bp_mem_req", mem_req, 1);
      chk("bp_no_fifo_req", fifo_req, 0);
      chk("bp_addr", mem_addr, 32'h3000);
    end
    mem_block = 1'b0;
    wait_done(d0, 100, "bp");

    // Abort during third word's write response wait
    push_words(10);
    d0 = done_cnt; w0 = wr_cnt;
    go(32'h4000, 10);
    wait_writes(w0, 3, "abort");
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    wait_done(d0, 100, "abort");
    chk("abort_writes", wr_cnt - w0, 3);
    chk("abort_remaining", remaining, 7);

    // Abort while idle must not leak into the next transfer
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    d0 = done_cnt; w0 = wr_cnt;
    go(32'h4800, 1);
    wait_done(d0, 100, "idle_abort");
    chk("idle_abort_writes", wr_cnt - w0, 1);

    // len = 0
    d0 = done_cnt; w0 = wr_cnt;
    go(32'h5000, 0);
    wait_done(d0, 5, "len0");
    repeat (3) @(negedge clk);
    chk("len0_writes", wr_cnt - w0, 0);

    // Address wrap and misaligned destination
    d0 = done_cnt; w0 = wr_cnt;
    go(32'hFFFF_FFFC, 2);
    wait_done(d0, 100, "wrap");
    chk("wrap_writes", wr_cnt - w0, 2);
    push_words(1);
    d0 = done_cnt;
    go(32'h1003, 1);
    wait_done(d0, 100, "misalign");

    // start while busy is ignored
    mem_block = 1'b1;
    push_words(4);
    d0 = done_cnt; w0 = wr_cnt;
    go(32'h6000, 4);
    begin
      int c = 0;
      while (!mem_req && c < 50) begin @(negedge clk); #2; c++; end
    end
    go(32'h7000, 9);
    #2;
    chk("busy_start_remaining", remaining, 4);
    chk("busy_start_busy", busy, 1);
    mem_block = 1'b0;
    wait_done(d0, 200, "busy_start");
    chk("busy_start_writes", wr_cnt - w0, 4);

    // Randomized transfers with throttled slaves and occasional aborts
    repeat (25) begin
      int n;
      fifo_pct = $urandom_range(30, 100);
      mem_pct  = $urandom_range(30, 100);
      max_dly  = $urandom_range(0, 3);
      n = $urandom_range(0, 8);
      push_words(n);
      d0 = done_cnt;
      go($urandom, n);
      if ($urandom_range(3) == 0) begin
        repeat ($urandom_range(1, 15)) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
      end
      wait_done(d0, 2000, "random");
    end
    fifo_pct = 100; mem_pct = 100; max_dly = 0;

    // Reset mid-transfer
    push_words(5);
    d0 = done_cnt; w0 = wr_cnt;
    go(32'h8000, 5);
    wait_writes(w0, 2, "rst_mid");
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); #2;
    chk_reset_vals("rst_mid");
    fifo_q.delete();
    exp_data.delete();
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    chk("rst_mid_no_done", done_cnt, d0);

    // Recovery after reset
    push_words(2);
    d0 = done_cnt; w0 = wr_cnt;
    go(32'h9000, 2);
    wait_done(d0, 100, "recover");
    chk("recover_writes", wr_cnt - w0, 2);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
